// File: rtl/fir_mc_if.sv
// Stream and coefficient-load bundle for fir_mc_engine.
// master = sample source / result sink side, slave = the engine.
interface fir_mc_if #(
  parameter int WIDTH    = 16,
  parameter int LENGTH   = 64,
  parameter int CHANNELS = 2,
  parameter int OUT_W    = 2*WIDTH+$clog2(LENGTH)
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW   = $clog2(LENGTH);

  // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
  // the producer holds valid and its payload stable until that edge, and ready
  // may not depend combinationally on valid.
  logic                    in_valid;
  logic                    in_ready;
  logic [CH_W-1:0]         in_ch;
  logic signed [WIDTH-1:0] in_data;

  logic                    coeff_we;
  logic [AW-1:0]           coeff_addr;
  logic signed [WIDTH-1:0] coeff_data;

  logic                    busy;
  logic                    out_valid;
  logic                    out_ready;
  logic [CH_W-1:0]         out_ch;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;

  modport master (
    output in_valid, in_ch, in_data, coeff_we, coeff_addr, coeff_data, out_ready,
    input  in_ready, busy, out_valid, out_ch, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_ch, in_data, coeff_we, coeff_addr, coeff_data, out_ready,
    output in_ready, busy, out_valid, out_ch, out_data, out_sat
  );
endinterface

// File: rtl/fir_mc_engine.sv
// Time-multiplexed multi-channel FIR: one MAC, per-channel histories, shared coefficients.
// Optional macro FIR_SATURATE_EN: clamp out-of-range results and flag out_sat (else wrap).
module fir_mc_engine #(
  parameter int WIDTH    = 16,
  parameter int LENGTH   = 64,
  parameter int CHANNELS = 2,
  parameter int SHIFT    = 0,
  parameter int OUT_W    = 2*WIDTH+$clog2(LENGTH)
) (
  input  logic       clk,
  input  logic       rst,
  fir_mc_if.slave    bus,
  output logic [1:0] state_dbg
);
  localparam int AW    = $clog2(LENGTH);
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int ACC_W = 2*WIDTH+AW;
  localparam int TOT   = CHANNELS*LENGTH;
  localparam int HW    = CH_W+AW;
  localparam logic [ACC_W:0] RND = ((ACC_W+1)'(1) << SHIFT) >> 1;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_MAC   = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t                  state;
  logic signed [WIDTH-1:0] hist  [TOT];
  logic signed [WIDTH-1:0] coeff [LENGTH];
  logic [AW-1:0]           wp    [CHANNELS];
  logic [HW-1:0]           clr_cnt;
  logic [CH_W-1:0]         ch_q;
  logic [AW-1:0]           k;
  logic signed [ACC_W-1:0] acc;
  logic [CH_W-1:0]         och_q;
  logic signed [OUT_W-1:0] odata_q;
  logic                    osat_q;

  logic                    accept;
  logic                    ch_ok;
  logic [AW-1:0]           rd_addr;
  logic signed [WIDTH-1:0] h_rd;
  logic signed [WIDTH-1:0] c_rd;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W:0]   acc_x;
  logic signed [ACC_W:0]   r;
  logic signed [OUT_W-1:0] r_out;
  logic                    r_sat;

  assign accept = (state == S_IDLE) && bus.in_valid;
  assign ch_ok  = 32'(bus.in_ch) < CHANNELS;

  // Newest sample sits at wp, so tap k reads k samples back, wrapping within the channel.
  assign rd_addr  = wp[ch_q] - k;
  assign h_rd     = hist[{ch_q, rd_addr}];
  assign c_rd     = coeff[k];
  assign prod     = h_rd * c_rd;
  assign acc_next = acc + {{AW{prod[2*WIDTH-1]}}, prod};

  // One guard bit keeps the rounding bias from overflowing before the shift.
  assign acc_x = {acc_next[ACC_W-1], acc_next} + RND;
  assign r     = acc_x >>> SHIFT;

`ifdef FIR_SATURATE_EN
  logic fits;
  assign fits = (&r[ACC_W:OUT_W-1]) | ~(|r[ACC_W:OUT_W-1]);

  always_comb begin
    r_out = r[OUT_W-1:0];
    r_sat = 1'b0;
    if (!fits) begin
      r_sat = 1'b1;
      r_out = r[ACC_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^r[ACC_W:OUT_W-1];
  assign r_out     = r[OUT_W-1:0];
  assign r_sat     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) begin
        hist[clr_cnt] <= '0;
      end else if (accept && ch_ok) begin
        hist[{bus.in_ch, wp[bus.in_ch]}] <= bus.in_data;
      end
    end
  end

  // Coefficients survive reset; loads only land while idle.
  always_ff @(posedge clk) begin
    if (!rst && state == S_IDLE && bus.coeff_we) begin
      coeff[bus.coeff_addr] <= bus.coeff_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_cnt <= '0;
      for (int i = 0; i < CHANNELS; i++) wp[i] <= '0;
      acc     <= '0;
      k       <= '0;
      ch_q    <= '0;
      och_q   <= '0;
      odata_q <= '0;
      osat_q  <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + HW'(1);
          if (clr_cnt == HW'(TOT-1)) state <= S_IDLE;
        end
        S_IDLE: begin
          if (accept && ch_ok) begin
            ch_q  <= bus.in_ch;
            acc   <= '0;
            k     <= '0;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_next;
          k   <= k + AW'(1);
          if (k == AW'(LENGTH-1)) begin
            wp[ch_q] <= wp[ch_q] + AW'(1);
            och_q    <= ch_q;
            odata_q  <= r_out;
            osat_q   <= r_sat;
            state    <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_CLEAR;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_valid = (state == S_OUT);
  assign bus.out_ch    = och_q;
  assign bus.out_data  = odata_q;
  assign bus.out_sat   = osat_q;
  assign state_dbg     = state;
endmodule

// File: tb/tb_fir_mc_engine.sv
// Bench for fir_mc_engine: three instances (wide/SHIFT0, 16-bit/SHIFT0, 16-bit/SHIFT1)
// share one stimulus stream and are checked against a sum-of-products reference model.
module tb_fir_mc_engine;
  localparam int WIDTH = 16, LENGTH = 4, CHANNELS = 2;
  localparam int ACC_W = 2*WIDTH+$clog2(LENGTH);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                    in_valid = 1'b0, out_ready = 1'b0, coeff_we = 1'b0;
  logic [0:0]              in_ch = '0;
  logic signed [WIDTH-1:0] in_data = '0, coeff_data = '0;
  logic [1:0]              coeff_addr = '0;
  logic [1:0]              st0, st1, st2;

  fir_mc_if #(.WIDTH(WIDTH), .LENGTH(LENGTH), .CHANNELS(CHANNELS), .OUT_W(ACC_W)) if0 ();
  fir_mc_if #(.WIDTH(WIDTH), .LENGTH(LENGTH), .CHANNELS(CHANNELS), .OUT_W(16))    if1 ();
  fir_mc_if #(.WIDTH(WIDTH), .LENGTH(LENGTH), .CHANNELS(CHANNELS), .OUT_W(16))    if2 ();

  assign if0.in_valid = in_valid;  assign if1.in_valid = in_valid;  assign if2.in_valid = in_valid;
  assign if0.in_ch = in_ch;        assign if1.in_ch = in_ch;        assign if2.in_ch = in_ch;
  assign if0.in_data = in_data;    assign if1.in_data = in_data;    assign if2.in_data = in_data;
  assign if0.coeff_we = coeff_we;  assign if1.coeff_we = coeff_we;  assign if2.coeff_we = coeff_we;
  assign if0.coeff_addr = coeff_addr; assign if1.coeff_addr = coeff_addr; assign if2.coeff_addr = coeff_addr;
  assign if0.coeff_data = coeff_data; assign if1.coeff_data = coeff_data; assign if2.coeff_data = coeff_data;
  assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

  fir_mc_engine #(.WIDTH(WIDTH), .LENGTH(LENGTH), .CHANNELS(CHANNELS), .SHIFT(0), .OUT_W(ACC_W))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave), .state_dbg(st0));
  fir_mc_engine #(.WIDTH(WIDTH), .LENGTH(LENGTH), .CHANNELS(CHANNELS), .SHIFT(0), .OUT_W(16))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave), .state_dbg(st1));
  fir_mc_engine #(.WIDTH(WIDTH), .LENGTH(LENGTH), .CHANNELS(CHANNELS), .SHIFT(1), .OUT_W(16))
    dut2 (.clk(clk), .rst(rst), .bus(if2.slave), .state_dbg(st2));

  // ---------------- reference model ----------------
  int          coef_m [LENGTH];
  int          hq [CHANNELS][$];
  logic [63:0] exp_q[$];
  int          exp_ch_q[$];

  function automatic longint model_acc(input int ch);
    longint s = 0;
    int n = hq[ch].size();
    for (int t = 0; t < LENGTH; t++)
      if (n-1-t >= 0) s += longint'(hq[ch][n-1-t]) * longint'(coef_m[t]);
    return s;
  endfunction

  function automatic longint narrow(input longint acc, input int sh, input int ow, output bit sat);
    longint r  = (acc + ((longint'(1) << sh) >> 1)) >>> sh;
    longint mx = (longint'(1) << (ow-1)) - 1;
    longint mn = -mx - 1;
    sat = 1'b0;
`ifdef FIR_SATURATE_EN
    if (r > mx) begin r = mx; sat = 1'b1; end
    else if (r < mn) begin r = mn; sat = 1'b1; end
`else
    r = r & ((longint'(1) << ow) - 1);
    if (r > mx) r -= (longint'(1) << ow);
`endif
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (!if0.in_ready && n < 200) begin @(negedge clk); n++; end
    if (!if0.in_ready) check("idle_timeout", 0, 1);
  endtask

  task automatic reset_dut();
    int n = 0;
    bit seen_v = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; coeff_we = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_flags", {if0.in_ready, if0.out_valid, if0.busy, if0.out_sat, if0.out_ch}, 5'b00100);
    check("rst_data", if0.out_data, 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < CHANNELS; c++) hq[c].delete();
    exp_q.delete(); exp_ch_q.delete();
    @(negedge clk);
    while (!if0.in_ready && n < 100) begin
      if (if0.out_valid) seen_v = 1'b1;
      n++;
      @(negedge clk);
    end
    check("clr_cycles", n, CHANNELS*LENGTH);
    check("clr_no_valid", seen_v, 0);
    check("dbg_idle", {st0, st1, st2}, 6'b010101);
  endtask

  task automatic write_coeff(input int a, input int v);
    logic signed [WIDTH-1:0] t;
    t = 16'(v);
    wait_idle();
    coeff_we = 1'b1; coeff_addr = 2'(a); coeff_data = t;
    coef_m[a] = int'(t);
    @(posedge clk); #1 coeff_we = 1'b0;
  endtask

  task automatic send(input int ch, input int data, input int hold,
                      input bit cw, input int caddr, input int cval, input bit poke,
                      output logic signed [63:0] g0, output logic signed [63:0] g1,
                      output logic signed [63:0] g2);
    logic signed [WIDTH-1:0] t;
    logic signed [63:0] held;
    longint acc, e;
    bit s;
    int n = 0;
    wait_idle();
    t = 16'(data);
    in_valid = 1'b1; in_ch = 1'(ch); in_data = t;
    if (cw) begin
      coeff_we = 1'b1; coeff_addr = 2'(caddr); coeff_data = 16'(cval);
      coef_m[caddr] = int'($signed(16'(cval)));
    end
    hq[ch].push_back(int'(t));
    if (hq[ch].size() > LENGTH) void'(hq[ch].pop_front());
    exp_q.push_back(64'(model_acc(ch)));
    exp_ch_q.push_back(ch);
    @(posedge clk); #1;
    in_valid = 1'b0; coeff_we = 1'b0;
    @(negedge clk);
    check("mac_in_ready", if0.in_ready, 0);
    if (poke) begin coeff_we = 1'b1; coeff_addr = 2'd0; coeff_data = 16'sd99; end
    while (!if0.out_valid && n < 50) begin
      @(posedge clk); #1 coeff_we = 1'b0;
      @(negedge clk);
      n++;
    end
    coeff_we = 1'b0;
    check("latency", n + 1, LENGTH + 1);
    held = if0.out_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check("bp_data", if0.out_data, held);
      check("bp_flags", {if0.out_valid, if0.in_ready, if0.busy, if0.out_ch}, {3'b101, 1'(ch)});
    end
    acc = longint'(exp_q.pop_front());
    check("out_ch", if0.out_ch, exp_ch_q.pop_front());
    e = narrow(acc, 0, ACC_W, s);
    check("d0_data", if0.out_data, e);   check("d0_sat", if0.out_sat, s);
    e = narrow(acc, 0, 16, s);
    check("d1_data", if1.out_data, e);   check("d1_sat", if1.out_sat, s);
    e = narrow(acc, 1, 16, s);
    check("d2_data", if2.out_data, e);   check("d2_sat", if2.out_sat, s);
    g0 = if0.out_data; g1 = if1.out_data; g2 = if2.out_data;
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    check("post_idle", {if0.out_valid, if0.in_ready, if0.busy}, 3'b010);
  endtask

  // ---------------- stimulus ----------------
  int imp_seq [5] = '{1, 0, 0, 0, 0};
  int imp_exp [5] = '{1, 2, 3, 4, 0};
  int ch1_exp [5] = '{10, 30, 60, 100, 100};

  initial begin
    logic signed [63:0] g0, g1, g2;
    reset_dut();
    for (int i = 0; i < LENGTH; i++) write_coeff(i, i + 1);

    // impulse on ch0, one transaction held off for 6 cycles
    for (int i = 0; i < 5; i++) begin
      send(0, imp_seq[i], (i == 2) ? 6 : 0, 1'b0, 0, 0, 1'b0, g0, g1, g2);
      check("impulse", g0, imp_exp[i]);
    end

    // channel isolation
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      send(0, imp_seq[i], 0, 1'b0, 0, 0, 1'b0, g0, g1, g2);
      check("iso_ch0", g0, imp_exp[i]);
      send(1, 10, 0, 1'b0, 0, 0, 1'b0, g0, g1, g2);
      check("iso_ch1", g0, ch1_exp[i]);
    end

    // overflow of the 16-bit outputs
    reset_dut();
    for (int i = 0; i < LENGTH; i++) write_coeff(i, 32767);
    for (int i = 0; i < 4; i++) send(0, 32767, 0, 1'b0, 0, 0, 1'b0, g0, g1, g2);
    check("ovf_wide", g0, 64'sd4294705156);
`ifdef FIR_SATURATE_EN
    check("ovf_narrow", g1, 32767);
    check("ovf_sat", if1.out_sat, 1);
`else
    check("ovf_narrow", g1, 4);
    check("ovf_sat", if1.out_sat, 0);
`endif

    // rounding and ignored coefficient write while busy
    reset_dut();
    write_coeff(0, 1);
    for (int i = 1; i < LENGTH; i++) write_coeff(i, 0);
    send(0, 3, 0, 1'b0, 0, 0, 1'b0, g0, g1, g2);
    check("round_pos", g2, 2);
    send(0, -3, 0, 1'b0, 0, 0, 1'b1, g0, g1, g2);
    check("round_neg", g2, -1);
    send(1, 3, 0, 1'b0, 0, 0, 1'b0, g0, g1, g2);
    check("busy_coeff_ignored", g0, 3);
    check("round_pos2", g2, 2);

    // coefficient write in the same cycle as an accept
    send(1, 5, 0, 1'b1, 0, 7, 1'b0, g0, g1, g2);
    check("same_cycle_coeff", g0, 35);

    // randomized traffic
    reset_dut();
    for (int i = 0; i < LENGTH; i++) write_coeff(i, int'($signed(16'($urandom))));
    for (int i = 0; i < 40; i++) begin
      send($urandom_range(0, CHANNELS-1), int'($signed(16'($urandom))), $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0), $urandom_range(0, LENGTH-1), int'($signed(16'($urandom))),
           ($urandom_range(0, 9) == 0), g0, g1, g2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fir_mc_engine.md
Name: fir_mc_engine

Overview:
- Multi-channel, time-multiplexed serial FIR engine.
- One shared MAC serves CHANNELS independent sample histories with shared, runtime-loadable coefficients.
- Valid/ready on input and output. Output is scaled with round-half-up and narrowed to OUT_W.
- Sits between the sample source (e.g. UART receive path) and the result sink; supersedes the fixed single-channel MAC datapath plus external controller.

Parameters:
- WIDTH, 16, signed sample and coefficient width
- LENGTH, 64, taps per channel (power of two, >=2)
- CHANNELS, 2, independent channels (>=1)
- SHIFT, 0, right-shift applied to accumulator before narrowing
- OUT_W, 2*WIDTH+$clog2(LENGTH), output width (ACC_W = 2*WIDTH+$clog2(LENGTH); OUT_W <= ACC_W)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  sample offered
- in_ready  out  1  engine accepts sample
- in_ch  in  max(1,$clog2(CHANNELS))  channel of offered sample
- in_data  in  WIDTH  signed sample
- coeff_we  in  1  coefficient write strobe
- coeff_addr  in  $clog2(LENGTH)  tap index
- coeff_data  in  WIDTH  signed coefficient
- busy  out  1  state != IDLE
- out_valid  out  1  result available
- out_ready  in  1  sink accepts result
- out_ch  out  max(1,$clog2(CHANNELS))  channel of result
- out_data  out  OUT_W  signed filtered result
- out_sat  out  1  result was clamped (see Optional Feature)

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset:
  - state <- CLEAR; all per-channel write pointers <- 0; accumulator <- 0.
  - in_ready=0, out_valid=0, out_data=0, out_ch=0, out_sat=0, busy=1.
  - Coefficients are NOT cleared.
- FSM states: CLEAR, IDLE, MAC, OUT.
- CLEAR:
  - Zeroes one history word per cycle; counter runs 0..CHANNELS*LENGTH-1.
  - Enters IDLE on the following cycle: exactly CHANNELS*LENGTH cycles with in_ready=0 after rst deasserts.
- IDLE:
  - in_ready=1. Handshake = in_valid & in_ready.
  - On accept:
    - in_data written to history[in_ch][wp[in_ch]].
    - Channel latched into ch_q; accumulator <- 0; tap counter k <- 0; go to MAC.
  - in_ch >= CHANNELS: sample dropped, stays IDLE.
- MAC (LENGTH cycles, in_ready=0):
  - Each cycle: acc += history[ch_q][(wp[ch_q]-k) mod LENGTH] * coeff[k]; k++.
  - Signed full-precision product (2*WIDTH), sign-extended into ACC_W; never overflows.
  - After k=LENGTH-1: wp[ch_q] increments (mod LENGTH), go to OUT.
- OUT:
  - out_valid=1; out_ch=ch_q; out_data/out_sat registered and held stable until out_valid & out_ready.
  - Then IDLE. out_ready is ignored outside OUT.
- Latency and throughput:
  - Input accept at cycle t -> out_valid at t+LENGTH+1.
  - Max throughput: one sample per LENGTH+2 cycles with out_ready held high.
- Scaling:
  - r = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, arithmetic.
  - r is then narrowed to OUT_W per Optional Feature.
- Coefficient writes:
  - Honoured only when state==IDLE; ignored otherwise (busy=1).
  - coeff_we and an input accept in the same IDLE cycle: new coefficient is used by that sample's MAC.
- Reset mid-operation (any state): abort and re-enter CLEAR; pending output is discarded.

Optional Feature:
- Macro: FIR_SATURATE_EN.
- Defined: r outside the signed OUT_W range is clamped to 2^(OUT_W-1)-1 or -2^(OUT_W-1), and out_sat=1 for that result; otherwise out_sat=0.
- Undefined: out_data = r[OUT_W-1:0] (two's-complement wrap); out_sat tied to 0.

Test Plan:
- Reset with CHANNELS=2, LENGTH=4 -> in_ready=0 for exactly 8 cycles, then 1; out_valid=0 throughout.
- Impulse: coeffs {1,2,3,4}, SHIFT=0; ch0 samples 1,0,0,0,0 -> out_data 1,2,3,4,0, out_ch=0; each out_valid arrives 5 cycles after accept.
- Channel isolation: interleave ch0 impulse with ch1 constant 10 -> ch0 sequence unchanged; ch1 outputs 10,30,60,100,100.
- Backpressure: out_ready low 6 cycles in OUT -> out_data/out_ch stable, in_ready=0, busy=1; accepted on release, then IDLE.
- Overflow, OUT_W=16, all coeffs 32767, four samples 32767 on ch0:
  - 4th output with FIR_SATURATE_EN -> 32767, out_sat=1.
  - Without the macro -> 0x0004, out_sat=0.
- Rounding, SHIFT=1, coeffs {1,0,0,0}:
  - Sample 3 -> 2.
  - Sample -3 -> -1.
  - Coeff write during MAC -> ignored; read-back via next impulse shows old value.
